// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control sequencer for the RV32I core.
// Walks FETCH -> DECODE -> EXEC -> [MEM] -> WB, with TRAP and HALT side paths,
// and keeps the retired-instruction counter.
// Optional feature macro: CTRL_CSR_EN (CSR instructions retire through WB
// with csr_we; when undefined they are treated as invalid and trap).
module cpu_ctrl_fsm #(
    parameter logic [31:0] TRAP_VEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_load,
    input  logic [5:0]  instr_id,
    input  logic [6:0]  opcode,
    input  logic        br_taken,
    output logic        alu_a_pc,
    output logic        alu_b_imm,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        csr_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        trap,
    output logic        halted,
    output logic [31:0] instret
);

    // Decoder instruction codes used for classification.
    localparam logic [5:0] I_INVALID = 6'd0;
    localparam logic [5:0] I_ECALL   = 6'd39;
    localparam logic [5:0] I_EBREAK  = 6'd40;
    localparam logic [5:0] I_CSRRW   = 6'd41;
    localparam logic [5:0] I_CSRRCI  = 6'd46;

    // RV32I major opcodes.
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_IMM, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH,
        C_LOAD, C_STORE, C_ECALL, C_EBREAK, C_CSR, C_INVALID
    } cls_t;

    state_t      state_q, state_d;
    cls_t        cls_q, cls_d, cls_dec;
    logic [31:0] instret_q, instret_d;

    // The trap target is applied by the PC mux; it is carried here for reference only.
    logic unused_trap_vec;
    assign unused_trap_vec = ^TRAP_VEC;

    // Classify the decoder output; valid during DECODE, captured into cls_q.
    always_comb begin
        cls_dec = C_INVALID;
        if (instr_id != I_INVALID) begin
            case (opcode)
                OP_LUI:    cls_dec = C_LUI;
                OP_AUIPC:  cls_dec = C_AUIPC;
                OP_JAL:    cls_dec = C_JAL;
                OP_JALR:   cls_dec = C_JALR;
                OP_BRANCH: cls_dec = C_BRANCH;
                OP_LOAD:   cls_dec = C_LOAD;
                OP_STORE:  cls_dec = C_STORE;
                OP_IMM:    cls_dec = C_IMM;
                OP_REG:    cls_dec = C_ALU;
                OP_FENCE:  cls_dec = C_ALU;
                OP_SYSTEM: begin
                    if (instr_id == I_ECALL)
                        cls_dec = C_ECALL;
                    else if (instr_id == I_EBREAK)
                        cls_dec = C_EBREAK;
                    else if (instr_id >= I_CSRRW && instr_id <= I_CSRRCI)
`ifdef CTRL_CSR_EN
                        cls_dec = C_CSR;
`else
                        cls_dec = C_INVALID;
`endif
                end
                default:   cls_dec = C_INVALID;
            endcase
        end
    end

    // State, instruction class and retired counter registers.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cls_q     <= C_INVALID;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            instret_q <= instret_d;
        end
    end

    // Next-state logic and Moore output decode (ir_load also follows imem_ack in FETCH).
    // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        instret_d = instret_q;
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        alu_a_pc  = 1'b0;
        alu_b_imm = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        csr_we    = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        trap      = 1'b0;
        halted    = 1'b0;
        instret   = instret_q;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d   = cls_dec;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WB;
                case (cls_q)
                    C_LOAD, C_STORE: begin
                        alu_b_imm = 1'b1;
                        state_d   = S_MEM;
                    end
                    C_IMM, C_JALR, C_LUI: alu_b_imm = 1'b1;
                    C_AUIPC: begin
                        alu_a_pc  = 1'b1;
                        alu_b_imm = 1'b1;
                    end
                    C_JAL:   alu_a_pc = 1'b1;
                    C_EBREAK: begin
                        state_d   = S_HALT;
                        instret_d = instret_q + 32'd1;
                    end
                    C_ECALL, C_INVALID: state_d = S_TRAP;
                    default: ;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == C_STORE);
                if (dmem_ack)
                    state_d = S_WB;
            end
            S_WB: begin
                pc_we     = 1'b1;
                rf_we     = 1'b1;
                state_d   = S_FETCH;
                instret_d = instret_q + 32'd1;
                case (cls_q)
                    C_BRANCH: begin
                        rf_we  = 1'b0;
                        pc_sel = br_taken ? 2'd1 : 2'd0;
                    end
                    C_STORE: rf_we = 1'b0;
                    C_LOAD:  wb_sel = 2'd1;
                    C_JAL: begin
                        wb_sel = 2'd2;
                        pc_sel = 2'd1;
                    end
                    C_JALR: begin
                        wb_sel = 2'd2;
                        pc_sel = 2'd2;
                    end
`ifdef CTRL_CSR_EN
                    C_CSR: begin
                        wb_sel = 2'd3;
                        csr_we = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            S_TRAP: begin
                pc_we   = 1'b1;
                pc_sel  = 2'd3;
                trap    = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_FETCH;
        endcase

        // Outputs read as idle for as long as reset is held.
        if (rst) begin
            imem_req  = 1'b0;
            ir_load   = 1'b0;
            alu_a_pc  = 1'b0;
            alu_b_imm = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            rf_we     = 1'b0;
            wb_sel    = 2'd0;
            csr_we    = 1'b0;
            pc_we     = 1'b0;
            pc_sel    = 2'd0;
            trap      = 1'b0;
            halted    = 1'b0;
            instret   = 32'd0;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed bench for cpu_ctrl_fsm. Each cycle's expected
// output vector is queued when the stimulus is driven and compared mid-cycle.
module tb_cpu_ctrl_fsm;

    typedef struct packed {
        logic        imem_req;
        logic        ir_load;
        logic        alu_a_pc;
        logic        alu_b_imm;
        logic        dmem_req;
        logic        dmem_we;
        logic        rf_we;
        logic [1:0]  wb_sel;
        logic        csr_we;
        logic        pc_we;
        logic [1:0]  pc_sel;
        logic        trap;
        logic        halted;
        logic [31:0] instret;
    } out_t;

    typedef struct {
        string tag;
        out_t  exp;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        br_taken = 1'b0;
    logic [5:0]  instr_id = 6'd0;
    logic [6:0]  opcode = 7'd0;

    logic        imem_req, ir_load, alu_a_pc, alu_b_imm, dmem_req, dmem_we;
    logic        rf_we, csr_we, pc_we, trap, halted;
    logic [1:0]  wb_sel, pc_sel;
    logic [31:0] instret;

    out_t  obs;
    item_t sb[$];
    int    n_checks = 0;
    int    n_fail = 0;

    cpu_ctrl_fsm dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
        .instr_id(instr_id), .opcode(opcode), .br_taken(br_taken),
        .alu_a_pc(alu_a_pc), .alu_b_imm(alu_b_imm),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .wb_sel(wb_sel), .csr_we(csr_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .trap(trap), .halted(halted),
        .instret(instret)
    );

    always #5 clk = ~clk;

    assign obs = '{imem_req, ir_load, alu_a_pc, alu_b_imm, dmem_req, dmem_we,
                   rf_we, wb_sel, csr_we, pc_we, pc_sel, trap, halted, instret};

    // Scoreboard consumer: compare the DUT outputs mid-cycle against the queued expectation.
    always @(negedge clk) begin
        item_t it;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            n_checks++;
            assert (obs === it.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
            end
        end
    end

    function automatic out_t e_idle(input logic [31:0] ic);
        out_t o = '0;
        o.instret = ic;
        return o;
    endfunction

    function automatic out_t e_fetch(input logic ack, input logic [31:0] ic);
        out_t o = e_idle(ic);
        o.imem_req = 1'b1;
        o.ir_load  = ack;
        return o;
    endfunction

    function automatic out_t e_exec(input logic a_pc, input logic b_imm, input logic [31:0] ic);
        out_t o = e_idle(ic);
        o.alu_a_pc  = a_pc;
        o.alu_b_imm = b_imm;
        return o;
    endfunction

    function automatic out_t e_mem(input logic we, input logic [31:0] ic);
        out_t o = e_idle(ic);
        o.dmem_req = 1'b1;
        o.dmem_we  = we;
        return o;
    endfunction

    function automatic out_t e_wb(input logic rfw, input logic [1:0] ws, input logic cw,
                                  input logic [1:0] ps, input logic [31:0] ic);
        out_t o = e_idle(ic);
        o.pc_we  = 1'b1;
        o.rf_we  = rfw;
        o.wb_sel = ws;
        o.csr_we = cw;
        o.pc_sel = ps;
        return o;
    endfunction

    function automatic out_t e_trap(input logic [31:0] ic);
        out_t o = e_idle(ic);
        o.pc_we  = 1'b1;
        o.pc_sel = 2'd3;
        o.trap   = 1'b1;
        return o;
    endfunction

    function automatic out_t e_halt(input logic [31:0] ic);
        out_t o = e_idle(ic);
        o.halted = 1'b1;
        return o;
    endfunction

    // Drive one cycle of inputs, queue its expected outputs, advance to just after the next edge.
    task automatic cyc(input string tag, input logic ia, input logic da, input logic bt,
                       input out_t exp);
        item_t it;
        imem_ack = ia;
        dmem_ack = da;
        br_taken = bt;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] id, input logic [6:0] op);
        instr_id = id;
        opcode   = op;
    endtask

    initial begin
        logic [31:0] ic;
        ic = 32'd0;
        @(posedge clk);
        #1;

        // Reset held: everything idle.
        cyc("reset0", 1, 1, 1, e_idle(0));
        cyc("reset1", 0, 0, 0, e_idle(0));
        rst = 1'b0;

        // addi with zero-wait fetch; imem_ack during DECODE must be ignored.
        set_instr(6'd19, 7'b0010011);
        cyc("addi_fetch", 1, 0, 0, e_fetch(1, ic));
        cyc("addi_dec",   1, 0, 0, e_idle(ic));
        cyc("addi_exec",  0, 1, 0, e_exec(0, 1, ic));
        cyc("addi_wb",    0, 0, 0, e_wb(1, 2'd0, 0, 2'd0, ic));
        ic = ic + 1;

        // lw with dmem_ack arriving on the 4th request cycle.
        set_instr(6'd13, 7'b0000011);
        cyc("lw_fetch", 1, 0, 0, e_fetch(1, ic));
        cyc("lw_dec",   0, 0, 0, e_idle(ic));
        cyc("lw_exec",  0, 0, 0, e_exec(0, 1, ic));
        cyc("lw_mem0",  0, 0, 0, e_mem(0, ic));
        cyc("lw_mem1",  0, 0, 0, e_mem(0, ic));
        cyc("lw_mem2",  0, 0, 0, e_mem(0, ic));
        cyc("lw_mem3",  0, 1, 0, e_mem(0, ic));
        cyc("lw_wb",    0, 0, 0, e_wb(1, 2'd1, 0, 2'd0, ic));
        ic = ic + 1;

        // sw zero-wait.
        set_instr(6'd18, 7'b0100011);
        cyc("sw_fetch", 1, 0, 0, e_fetch(1, ic));
        cyc("sw_dec",   0, 0, 0, e_idle(ic));
        cyc("sw_exec",  0, 0, 0, e_exec(0, 1, ic));
        cyc("sw_mem",   0, 1, 0, e_mem(1, ic));
        cyc("sw_wb",    0, 0, 0, e_wb(0, 2'd0, 0, 2'd0, ic));
        ic = ic + 1;

        // beq taken, with one imem wait cycle; br_taken in EXEC has no effect.
        set_instr(6'd5, 7'b1100011);
        cyc("beq1_wait",  0, 0, 0, e_fetch(0, ic));
        cyc("beq1_fetch", 1, 0, 0, e_fetch(1, ic));
        cyc("beq1_dec",   0, 0, 1, e_idle(ic));
        cyc("beq1_exec",  0, 0, 1, e_exec(0, 0, ic));
        cyc("beq1_wb",    0, 0, 1, e_wb(0, 2'd0, 0, 2'd1, ic));
        ic = ic + 1;

        // beq not taken.
        cyc("beq0_fetch", 1, 0, 0, e_fetch(1, ic));
        cyc("beq0_dec",   0, 0, 0, e_idle(ic));
        cyc("beq0_exec",  0, 0, 1, e_exec(0, 0, ic));
        cyc("beq0_wb",    0, 0, 0, e_wb(0, 2'd0, 0, 2'd0, ic));
        ic = ic + 1;

        // jal and jalr.
        set_instr(6'd3, 7'b1101111);
        cyc("jal_fetch", 1, 0, 0, e_fetch(1, ic));
        cyc("jal_dec",   0, 0, 0, e_idle(ic));
        cyc("jal_exec",  0, 0, 0, e_exec(1, 0, ic));
        cyc("jal_wb",    0, 0, 0, e_wb(1, 2'd2, 0, 2'd1, ic));
        ic = ic + 1;
        set_instr(6'd4, 7'b1100111);
        cyc("jalr_fetch", 1, 0, 0, e_fetch(1, ic));
        cyc("jalr_dec",   0, 0, 0, e_idle(ic));
        cyc("jalr_exec",  0, 0, 0, e_exec(0, 1, ic));
        cyc("jalr_wb",    0, 0, 0, e_wb(1, 2'd2, 0, 2'd2, ic));
        ic = ic + 1;

        // i_invalid then ecall: trap pulse, instret unchanged.
        set_instr(6'd0, 7'b0000000);
        cyc("inv_fetch", 1, 0, 0, e_fetch(1, ic));
        cyc("inv_dec",   0, 0, 0, e_idle(ic));
        cyc("inv_exec",  0, 0, 0, e_exec(0, 0, ic));
        cyc("inv_trap",  0, 0, 0, e_trap(ic));
        set_instr(6'd39, 7'b1110011);
        cyc("ecall_fetch", 1, 0, 0, e_fetch(1, ic));
        cyc("ecall_dec",   0, 0, 0, e_idle(ic));
        cyc("ecall_exec",  0, 0, 0, e_exec(0, 0, ic));
        cyc("ecall_trap",  0, 0, 0, e_trap(ic));

        // csrrw: retires through WB when CSRs are built in, otherwise traps.
        set_instr(6'd41, 7'b1110011);
        cyc("csr_fetch", 1, 0, 0, e_fetch(1, ic));
        cyc("csr_dec",   0, 0, 0, e_idle(ic));
        cyc("csr_exec",  0, 0, 0, e_exec(0, 0, ic));
`ifdef CTRL_CSR_EN
        cyc("csr_wb",    0, 0, 0, e_wb(1, 2'd3, 1, 2'd0, ic));
        ic = ic + 1;
`else
        cyc("csr_trap",  0, 0, 0, e_trap(ic));
`endif

        // ebreak: halt, counted once, imem_ack ignored thereafter.
        set_instr(6'd40, 7'b1110011);
        cyc("ebrk_fetch", 1, 0, 0, e_fetch(1, ic));
        cyc("ebrk_dec",   0, 0, 0, e_idle(ic));
        cyc("ebrk_exec",  0, 0, 0, e_exec(0, 0, ic));
        ic = ic + 1;
        cyc("halt0", 1, 1, 0, e_halt(ic));
        cyc("halt1", 1, 0, 0, e_halt(ic));
        cyc("halt2", 0, 0, 0, e_halt(ic));

        // Reset mid-HALT clears asynchronously; fetch resumes on the first free cycle.
        rst = 1'b1;
        cyc("rst_halt", 1, 0, 0, e_idle(0));
        rst = 1'b0;
        cyc("post_rst_fetch", 0, 0, 0, e_fetch(0, 0));
        cyc("post_rst_ack",   1, 0, 0, e_fetch(1, 0));

        n_checks++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
